// File: rtl/orb_serializer_if.sv
// Frame-RAM read port, run request and serial telemetry outputs of the orbital serializer.
interface orb_serializer_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned WORD_W = 12
);
   logic              en;
   logic [ADDR_W-1:0] rdAddr;
   logic              rdEn;
   logic [WORD_W-1:0] rdData;
   logic              serOut;
   logic              bitStb;
   logic              wordStb;
   logic              frameStb;
   logic              SW;
   logic              busy;

   modport master (
      input  en, rdData,
      output rdAddr, rdEn, serOut, bitStb, wordStb, frameStb, SW, busy
   );

   modport slave (
      output en, rdData,
      input  rdAddr, rdEn, serOut, bitStb, wordStb, frameStb, SW, busy
   );
endinterface

// File: rtl/orb_serializer.sv
// Reads orbital words from the frame RAM and emits them MSB-first as a gap-free bitstream,
// marking word 0 of each frame and toggling the packer page select at every frame start.
module orb_serializer #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned WORD_W  = 12,
   parameter int unsigned BIT_DIV = 8
) (
   input logic              clk,
   input logic              rst,
   orb_serializer_if.master bus
);
   localparam int unsigned DIV_W = $clog2(BIT_DIV);
   localparam int unsigned BIT_W = $clog2(WORD_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

   typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_en_q, rd_en_d;
   logic              fetch_dly_q, fetch_dly_d;
   logic [WORD_W-1:0] sh_reg_q, sh_reg_d;
   logic [WORD_W-1:0] nxt_word_q, nxt_word_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              ser_out_q, ser_out_d;
   logic              bit_stb_q, bit_stb_d;
   logic              word_stb_q, word_stb_d;
   logic              frame_stb_q, frame_stb_d;
   logic              sw_q, sw_d;
   logic              busy_q, busy_d;

   logic              do_load;
   logic [WORD_W-1:0] load_src;
   logic [WORD_W-1:0] load_word;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] addr_inc;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      addr_cnt_d  = addr_cnt_q;
      rd_addr_d   = rd_addr_q;
      rd_en_d     = 1'b0;
      fetch_dly_d = rd_en_q;
      sh_reg_d    = sh_reg_q;
      nxt_word_d  = nxt_word_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      ser_out_d   = ser_out_q;
      bit_stb_d   = 1'b0;
      word_stb_d  = 1'b0;
      frame_stb_d = 1'b0;
      sw_d        = sw_q;
      busy_d      = busy_q;
      do_load     = 1'b0;
      load_src    = bus.rdData;
      load_word   = '0;
      load_addr   = addr_cnt_q;
      addr_inc    = addr_cnt_q + ADDR_W'(1);

      // Prefetched word arrives one cycle after the RAM samples the strobe
      if (fetch_dly_q) nxt_word_d = bus.rdData;

      case (state_q)
         IDLE: begin
            ser_out_d = 1'b0;
            if (bus.en) begin
               rd_addr_d = addr_cnt_q;
               rd_en_d   = 1'b1;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            do_load   = 1'b1;
            load_src  = bus.rdData;
            load_addr = addr_cnt_q;
         end
         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (bit_cnt_q != BIT_LAST) begin
                  sh_reg_d  = {sh_reg_q[WORD_W-2:0], sh_reg_q[WORD_W-1]};
                  ser_out_d = sh_reg_q[WORD_W-2];
                  bit_stb_d = 1'b1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end else if (bus.en) begin
                  do_load   = 1'b1;
                  load_src  = nxt_word_q;
                  load_addr = addr_inc;
               end else begin
                  addr_cnt_d = '0;
                  ser_out_d  = 1'b0;
                  state_d    = IDLE;
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Word start: marker on address 0, strobes, and prefetch of the following address
      if (do_load) begin
         load_word = load_src;
         if (load_addr == '0) load_word[WORD_W-1] = 1'b1;
         sh_reg_d    = load_word;
         ser_out_d   = load_word[WORD_W-1];
         bit_stb_d   = 1'b1;
         word_stb_d  = 1'b1;
         frame_stb_d = (load_addr == '0);
         sw_d        = sw_q ^ (load_addr == '0);
         div_cnt_d   = '0;
         bit_cnt_d   = '0;
         addr_cnt_d  = load_addr;
         rd_addr_d   = load_addr + ADDR_W'(1);
         rd_en_d     = 1'b1;
         state_d     = SHIFT;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_cnt_q  <= '0;
         rd_addr_q   <= '0;
         rd_en_q     <= 1'b0;
         fetch_dly_q <= 1'b0;
         sh_reg_q    <= '0;
         nxt_word_q  <= '0;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         ser_out_q   <= 1'b0;
         bit_stb_q   <= 1'b0;
         word_stb_q  <= 1'b0;
         frame_stb_q <= 1'b0;
         sw_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_cnt_q  <= addr_cnt_d;
         rd_addr_q   <= rd_addr_d;
         rd_en_q     <= rd_en_d;
         fetch_dly_q <= fetch_dly_d;
         sh_reg_q    <= sh_reg_d;
         nxt_word_q  <= nxt_word_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_out_q   <= ser_out_d;
         bit_stb_q   <= bit_stb_d;
         word_stb_q  <= word_stb_d;
         frame_stb_q <= frame_stb_d;
         sw_q        <= sw_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.rdAddr   = rd_addr_q;
   assign bus.rdEn     = rd_en_q;
   assign bus.serOut   = ser_out_q;
   assign bus.bitStb   = bit_stb_q;
   assign bus.wordStb  = word_stb_q;
   assign bus.frameStb = frame_stb_q;
   assign bus.SW       = sw_q;
   assign bus.busy     = busy_q;
endmodule

// File: doc/orb_serializer.md
# orb_serializer

Reader/transmitter end of the orbital frame buffer. Fetches 12-bit orbital words sequentially from the 2048×12 frame RAM that the packer fills, and serialises them MSB-first as a continuous, gap-free telemetry bitstream. Inserts a frame marker on word 0. Produces the `SW` page-toggle that restarts the packer's word/packet counters at every frame start.

## Interface
Parameters:
- `ADDR_W`, default 11: RAM address width; frame length = 2^ADDR_W words.
- `WORD_W`, default 12: RAM word width and bits per serial word.
- `BIT_DIV`, default 8: clk cycles per serial bit; legal range ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: run request, level-sensitive.
- `rdAddr` out ADDR_W: RAM read address, registered.
- `rdEn` out 1: RAM read strobe, one-cycle pulse.
- `rdData` in WORD_W: RAM read data; valid on the 2nd rising edge after the edge that drives `rdAddr`/`rdEn` (synchronous RAM, 1-cycle latency).
- `serOut` out 1: serial data, MSB first.
- `bitStb` out 1: one-cycle pulse on the first cycle of every bit.
- `wordStb` out 1: one-cycle pulse on the first cycle of bit 11 of every word.
- `frameStb` out 1: one-cycle pulse coincident with `wordStb` for the word at address 0.
- `SW` out 1: page toggle to the packer; inverts at every frame start.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Reset values: `rdAddr`=0, `rdEn`=0, `serOut`=0, `bitStb`=0, `wordStb`=0, `frameStb`=0, `SW`=0, `busy`=0. Internal word address `addrCnt`=0, state IDLE.
- States:
  - IDLE: `serOut`=0. If `en`=1, drive `rdAddr`←`addrCnt` and `rdEn`←1, then go to FETCH.
  - FETCH: `rdEn`←0, then go to LOAD.
  - LOAD: `shReg`←`rdData`. Bit 11 is forced to 1 when `addrCnt`=0 (frame marker; the packer always writes 0 there). Drive `serOut`←bit 11 and pulse `bitStb`/`wordStb`. If `addrCnt`=0, also pulse `frameStb` and toggle `SW`. Clear `divCnt` and `bitCnt`, then go to SHIFT.
  - SHIFT: `divCnt` counts 0..BIT_DIV-1. On wrap:
    - If `bitCnt`<11, shift left, drive `serOut` with the new MSB, pulse `bitStb`, and increment `bitCnt`.
    - If `bitCnt`=11 (word end), increment `addrCnt` modulo 2^ADDR_W.
      - If `en`=1, load `shReg` from `nxtWord` (marker rule applies to the new `addrCnt`), with the same strobes and `SW`/`frameStb` behaviour as LOAD.
      - If `en`=0, set `addrCnt`←0, `serOut`←0, and go to IDLE.
- Prefetch: in the first cycle of each word (`bitCnt`=0, `divCnt`=0), drive `rdAddr`←`addrCnt`+1 (mod 2^ADDR_W) and pulse `rdEn`. Capture `rdData` into `nxtWord` two edges later. Word boundaries therefore show no gap. BIT_DIV≥2 guarantees `nxtWord` is valid before the word end.
- Arithmetic: `addrCnt` and the prefetch address wrap 2^ADDR_W-1 → 0 silently.
- `en` is sampled only in IDLE and at word end. Deassertion mid-word always completes the current 12 bits. A stop always restarts the next run at address 0, with a marker, `frameStb`, and an `SW` toggle.
- Reset mid-operation clears all state and outputs immediately. No partial word is emitted after reset release unless a new `en` arrives.

## Timing
- Start latency: `en` sampled at edge T (IDLE) → `rdEn`=1, `rdAddr`=0 after T. FETCH at T+1. `rdData` captured at T+2. The first `serOut` bit, `bitStb`, `wordStb`, `frameStb` and the `SW` toggle are all valid after edge T+2.
- Each bit is held exactly BIT_DIV cycles. A word lasts 12·BIT_DIV cycles. `wordStb` period is 12·BIT_DIV while running, and the frame period is 2^ADDR_W·12·BIT_DIV cycles.
- Prefetch `rdEn` coincides with the `wordStb` cycle of the current word.
- After word end with `en`=0, `busy` falls in the cycle after the last bit's final cycle.

## Test plan
- Reset: assert `rst`=0 mid-SHIFT → all outputs 0 the same cycle. Release with `en`=0 → outputs stay 0 and `rdEn` never pulses.
- First word: RAM[0]=0x2A8, BIT_DIV=4, raise `en` → `rdAddr`=0 read; `serOut` = 1,0,1,0,1,0,1,0,1,0,0,0, each bit held 4 cycles, first bit after edge T+2; `frameStb`=1 once; `SW` 0→1.
- Back-to-back: RAM[1]=0xFFF, RAM[2]=0x001 → `rdEn` with `rdAddr`=1 in word 0's first cycle. Stream continues without gap as twelve 1s, then 0×11 then 1. `wordStb` every 48 cycles; no marker on words 1–2.
- Wrap: ADDR_W=3, BIT_DIV=2, `en` held → prefetch address sequence 1..7,0. Word at address 0 repeats every 8 words with marker=1. `SW` toggles and `frameStb` pulses every 192 cycles.
- Stop/restart: drop `en` at bit 5 of word 3 → bits 6..11 still emitted, then IDLE with `serOut`=0 and `busy`=0. Re-raise `en` → reads address 0, marker set, `SW` toggles.
- Minimum divider: BIT_DIV=2 with distinct random RAM contents over 16 words → serial stream equals the RAM words MSB-first, with the marker on word 0 only.
